// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller.
// Holds the FSM state encoding, the default operand width and the iteration-count width.
package mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_dp.sv
// Shift-add multiplier datapath: operand registers, {carry, 2*WIDTH} product register, adder.
// One partial-product iteration per step; the carry is absorbed by the right shift.
module mult_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               init,
  input  logic               step,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH:0]     sum_next;

  // Upper half plus (conditionally) the multiplicand, with one extra bit for the carry.
  assign sum_next = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (prod_reg[0] ? a_reg : {WIDTH{1'b0}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      prod_reg <= '0;
    end else begin
      if (load) begin
        a_reg <= a;
        b_reg <= b;
      end
      if (init) begin
        prod_reg <= {{WIDTH{1'b0}}, b_reg};
      end else if (step) begin
        prod_reg <= {sum_next, prod_reg[WIDTH-1:1]};
      end
    end
  end

  assign product = prod_reg;

endmodule

// File: rtl/mult_arbiter.sv
// Two-port round-robin front end and sequencer for the shared shift-add multiplier.
// Arbitrates only in IDLE; returns the product and requester id over a valid/ready channel.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_product,
  output logic               resp_id,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             last_reg;
  logic             id_reg;
  logic             resp_valid_reg;
  logic             busy_reg;

  logic             grant_id;
  logic             idle;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // On a tie, favour the requester that was not served last.
  assign grant_id = (&req_valid) ? ~last_reg : req_valid[1];
  assign idle     = rst_n & (state_reg == ST_IDLE);

  assign req_ready[0] = idle & req_valid[0] & ~grant_id;
  assign req_ready[1] = idle & req_valid[1] & grant_id;
  assign accept       = |(req_valid & req_ready);

  assign sel_a = grant_id ? req_a1 : req_a0;
  assign sel_b = grant_id ? req_b1 : req_b0;

  mult_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .a      (sel_a),
    .b      (sel_b),
    .init   (state_reg == ST_INIT),
    .step   (state_reg == ST_CALC),
    .product(resp_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      last_reg       <= 1'b1;
      id_reg         <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            id_reg    <= grant_id;
            last_reg  <= grant_id;
            busy_reg  <= 1'b1;
            state_reg <= ST_INIT;
          end
        end
        ST_INIT: begin
          count_reg <= '0;
          state_reg <= ST_CALC;
        end
        ST_CALC: begin
          count_reg <= count_reg + 1'b1;
          if (count_reg == CNT_W'(WIDTH - 1)) begin
            resp_valid_reg <= 1'b1;
            state_reg      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_id    = id_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter: handshakes, latency, round-robin,
// back-pressure, mid-operation reset and operand edge cases.
module tb_mult_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_product;
  logic        resp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mult_arbiter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_product(resp_product),
    .resp_id     (resp_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request from one requester alone, accept it, drop valid.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin req_a0 = a; req_b0 = b; req_valid = 2'b01; end
    else         begin req_a1 = a; req_b1 = b; req_valid = 2'b10; end
    #1;
    chk("issue_ready", 64'(req_ready), (id == 0) ? 64'd1 : 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    $display("issue id=%0d a=0x%0h b=0x%0h", id, a, b);
  endtask

  // Called at the negedge after the accept edge; counts edges until resp_valid.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (resp_valid !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Called at a negedge in DONE: complete the response handshake.
  task automatic respond();
    chk("done_ready_low", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_resp_busy", 64'(busy), 64'd0);
  endtask

  task automatic op(input int id, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input string tag);
    int   lat;
    logic bok;
    issue(id, a, b);
    wait_done(lat, bok);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_busy"}, 64'(bok), 64'd1);
    chk({tag, "_prod"}, resp_product, exp);
    chk({tag, "_id"}, 64'(resp_id), 64'(id));
    $display("resp %s id=%0d product=0x%0h latency=%0d", tag, resp_id, resp_product, lat);
    respond();
  endtask

  initial begin
    int   lat;
    logic bok;
    logic no_resp;
    rst_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_product", resp_product, 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    op(0, 32'd3, 32'd5, 64'd15, "single");
    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");

    // Tie: both requesters hold valid; service must alternate starting with id0.
    req_a0 = 32'd2; req_b0 = 32'd7; req_a1 = 32'd4; req_b1 = 32'd9;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      @(posedge clk);
      @(negedge clk);
      wait_done(lat, bok);
      chk("tie_lat", 64'(lat), 64'd33);
      chk("tie_id", 64'(resp_id), 64'(k % 2));
      chk("tie_prod", resp_product, (k % 2 == 0) ? 64'd14 : 64'd36);
      $display("resp tie%0d id=%0d product=%0d", k, resp_id, resp_product);
      respond();
    end
    req_valid = 2'b00;

    // Back-pressure: stall DONE for 10 cycles while requester 1 waits.
    issue(0, 32'd6, 32'd7);
    wait_done(lat, bok);
    req_a1 = 32'd5; req_b1 = 32'd5; req_valid = 2'b10;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_prod", resp_product, 64'd42);
      chk("bp_id", 64'(resp_id), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    $display("resp backpressure id=%0d product=%0d", resp_id, resp_product);
    respond();
    chk("bp_resume_ready", 64'(req_ready), 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done(lat, bok);
    chk("bp_next_lat", 64'(lat), 64'd33);
    chk("bp_next_prod", resp_product, 64'd25);
    chk("bp_next_id", 64'(resp_id), 64'd1);
    $display("resp after_bp id=%0d product=%0d", resp_id, resp_product);
    respond();

    // Reset at CALC iteration 10 aborts the operation.
    issue(1, 32'h1234, 32'h99);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(resp_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_prod", resp_product, 64'd0);
    chk("abort_id", 64'(resp_id), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_resp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) no_resp = 1'b0;
    end
    chk("abort_no_resp", 64'(no_resp), 64'd1);
    $display("abort reset checked");
    op(0, 32'h8000_0000, 32'd2, 64'h1_0000_0000, "post_abort");

    op(0, 32'd0, 32'h1234_5678, 64'd0, "zero");
    op(1, 32'h1234_5678, 32'd1, 64'h1234_5678, "one");

    // Operands changed right after acceptance must not matter.
    issue(0, 32'd1000, 32'd1000);
    req_a0 = 32'hDEAD_BEEF; req_b0 = 32'hCAFE_F00D;
    wait_done(lat, bok);
    chk("chg_lat", 64'(lat), 64'd33);
    chk("chg_prod", resp_product, 64'd1000000);
    $display("resp chg id=%0d product=%0d", resp_id, resp_product);
    respond();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
